// File: rtl/uart_packet_tx.sv
// uart_packet_tx: 8N1 transmitter sending HEADER then data_in bytes 0..7; in clk, rst, data_in[63:0], tx_start; out tx, busy, done
module uart_packet_tx #(
    parameter int         CLKS_PER_BIT = 2474,
    parameter logic [7:0] HEADER       = 8'h02,
    parameter int         GAP_BITS     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic        tx_start,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, DONE} state_t;
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [3:0]  r_byte_idx;
    logic [3:0]  r_gap_cnt;
    logic [7:0]  r_cur_byte;
    logic [63:0] r_payload;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic        w_tick;
    assign w_tick = r_cnt == 16'(CLKS_PER_BIT - 1);
    assign tx     = r_tx;
    assign busy   = r_busy;
    assign done   = r_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_gap_cnt  <= '0;
            r_cur_byte <= '0;
            r_payload  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx   <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_cur_byte[r_bit_idx] : 1'b1;
            r_busy <= r_state != IDLE && r_state != DONE;
            r_done <= r_state == DONE;
            r_cnt  <= (r_state == IDLE || r_state == DONE || w_tick) ? '0 : r_cnt + 16'd1;
            case (r_state)
                IDLE: if (tx_start) begin
                    r_payload  <= data_in;
                    r_byte_idx <= '0;
                    r_cur_byte <= HEADER;
                    r_state    <= START;
                end
                START: if (w_tick) begin
                    r_bit_idx <= '0;
                    r_state   <= DATA;
                end
                DATA: if (w_tick) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) r_state <= STOP;
                end
                STOP: if (w_tick) begin
                    if (r_byte_idx == 4'd8) begin
                        r_state <= DONE;
                    end else begin
                        r_cur_byte <= r_payload[{r_byte_idx[2:0], 3'b000} +: 8];
                        r_byte_idx <= r_byte_idx + 4'd1;
                        r_gap_cnt  <= '0;
                        r_state    <= (GAP_BITS > 0) ? GAP : START;
                    end
                end
                GAP: if (w_tick) begin
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                    if (r_gap_cnt == 4'(GAP_BITS - 1)) r_state <= START;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: directed bench for uart_packet_tx with gap and no-gap instances
module tb_uart_packet_tx;
    localparam int CPB = 16;
    localparam int T1  = 98 * CPB;
    localparam int T0  = 90 * CPB;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] data_in = '0;
    logic        tx_start1 = 1'b0;
    logic        tx_start0 = 1'b0;
    logic        tx1, busy1, done1, tx0, busy0, done0;
    logic        cap_tx   [0:2047];
    logic        cap_busy [0:2047];
    logic        cap_done [0:2047];
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    uart_packet_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'h02), .GAP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .tx_start(tx_start1),
        .tx(tx1), .busy(busy1), .done(done1));
    uart_packet_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'h02), .GAP_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .tx_start(tx_start0),
        .tx(tx0), .busy(busy0), .done(done0));
    function automatic logic exp_bit(input logic [63:0] d, input int g, input int b);
        int slot = b / (10 + g);
        int pos  = b % (10 + g);
        logic [7:0] v;
        v = (slot == 0) ? 8'h02 : 8'(d >> (8 * (slot - 1)));
        return (pos == 0) ? 1'b0 : (pos <= 8) ? v[pos - 1] : 1'b1;
    endfunction
    function automatic logic [7:0] decode(input int g, input int i);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = cap_tx[1 + i * (10 + g) * CPB + (1 + j) * CPB + CPB / 2];
        return v;
    endfunction
    function automatic int count_done(input int len);
        int n = 0;
        for (int k = 0; k <= len; k++) if (cap_done[k] === 1'b1) n++;
        return n;
    endfunction
    function automatic int first_done(input int len);
        for (int k = 0; k <= len; k++) if (cap_done[k] === 1'b1) return k;
        return -1;
    endfunction
    function automatic int busy_bad(input int len, input int t);
        for (int k = 0; k <= len; k++) if (cap_busy[k] !== (k >= 1 && k <= t)) return k;
        return -1;
    endfunction
    task automatic capture(input bit sel0, input int len, input int chg_at, input int re_at, input int rst_at);
        if (sel0) tx_start0 = 1'b1; else tx_start1 = 1'b1;
        @(posedge clk); #1;
        cap_tx[0]   = sel0 ? tx0 : tx1;
        cap_busy[0] = sel0 ? busy0 : busy1;
        cap_done[0] = sel0 ? done0 : done1;
        for (int k = 1; k <= len; k++) begin
            tx_start1 = !sel0 && k == re_at;
            tx_start0 = sel0 && k == re_at;
            rst = k == rst_at;
            if (k == chg_at) data_in = '0;
            @(posedge clk); #1;
            cap_tx[k]   = sel0 ? tx0 : tx1;
            cap_busy[k] = sel0 ? busy0 : busy1;
            cap_done[k] = sel0 ? done0 : done1;
        end
        tx_start0 = 1'b0;
        tx_start1 = 1'b0;
        rst = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx1, busy1, done1, tx0, busy0, done0} !== 6'b100100) begin
            errors++;
            $display("FAIL reset_state: got %b expected 100100", {tx1, busy1, done1, tx0, busy0, done0});
        end
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({tx1, busy1, done1, tx0, busy0, done0} !== 6'b100100) begin
                errors++;
                $display("FAIL idle_cycle_%0d: got %b expected 100100", k, {tx1, busy1, done1, tx0, busy0, done0});
            end
        end
    endtask
    task automatic test_frame;
        logic [7:0] e [0:8];
        logic [63:0] d = 64'h8877665544332211;
        int bad;
        e = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        data_in = d;
        capture(1'b0, T1 + 3, -1, -1, -1);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (decode(1, i) !== e[i]) begin
                errors++;
                $display("FAIL frame_byte_%0d: got %h expected %h", i, decode(1, i), e[i]);
            end
        end
        for (int b = 0; b < 98; b++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) if (cap_tx[1 + b * CPB + c] !== exp_bit(d, 1, b)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL frame_bit_%0d: %0d cycles wrong, expected level %b", b, bad, exp_bit(d, 1, b));
            end
        end
        checks++;
        if (busy_bad(T1 + 3, T1) != -1) begin
            errors++;
            $display("FAIL frame_busy: wrong at cycle %0d, expected high only for 1..%0d", busy_bad(T1 + 3, T1), T1);
        end
        checks++;
        if (count_done(T1 + 3) != 1 || first_done(T1 + 3) != T1 + 1) begin
            errors++;
            $display("FAIL frame_done: got %0d pulses first at %0d expected 1 at %0d", count_done(T1 + 3), first_done(T1 + 3), T1 + 1);
        end
        checks++;
        if (cap_tx[T1 + 1] !== 1'b1) begin
            errors++;
            $display("FAIL frame_idle_tx: got %b expected 1", cap_tx[T1 + 1]);
        end
    endtask
    task automatic test_payload_latch;
        logic [7:0] e [0:8];
        e = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        data_in = 64'h8877665544332211;
        capture(1'b0, T1 + 3, 5, 200, -1);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (decode(1, i) !== e[i]) begin
                errors++;
                $display("FAIL latch_byte_%0d: got %h expected %h", i, decode(1, i), e[i]);
            end
        end
        checks++;
        if (count_done(T1 + 3) != 1 || first_done(T1 + 3) != T1 + 1) begin
            errors++;
            $display("FAIL latch_done: got %0d pulses first at %0d expected 1 at %0d", count_done(T1 + 3), first_done(T1 + 3), T1 + 1);
        end
    endtask
    task automatic test_back_to_back;
        logic [7:0] e [0:8];
        e = '{8'h02, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        data_in = 64'h0123456789ABCDEF;
        capture(1'b0, T1 + 20, -1, T1 + 1, -1);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (decode(1, i) !== e[i]) begin
                errors++;
                $display("FAIL order_byte_%0d: got %h expected %h", i, decode(1, i), e[i]);
            end
        end
        checks++;
        if (busy_bad(T1 + 20, T1) != -1 || count_done(T1 + 20) != 1) begin
            errors++;
            $display("FAIL done_state_start: busy wrong at %0d, %0d done pulses, expected none and 1", busy_bad(T1 + 20, T1), count_done(T1 + 20));
        end
        capture(1'b0, T1 + 4, -1, T1 + 2, -1);
        checks++;
        if ({cap_busy[T1 + 2], cap_busy[T1 + 3], cap_tx[T1 + 3]} !== 3'b010) begin
            errors++;
            $display("FAIL idle_restart: got busy/busy/tx %b expected 010", {cap_busy[T1 + 2], cap_busy[T1 + 3], cap_tx[T1 + 3]});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
    task automatic test_gap0;
        logic [7:0] e [0:8];
        logic [63:0] d = 64'hFF00FF00FF00FF00;
        int bad;
        e = '{8'h02, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        data_in = d;
        capture(1'b1, T0 + 3, -1, -1, -1);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (decode(0, i) !== e[i]) begin
                errors++;
                $display("FAIL gap0_byte_%0d: got %h expected %h", i, decode(0, i), e[i]);
            end
        end
        bad = 0;
        for (int b = 0; b < 90; b++)
            for (int c = 0; c < CPB; c++) if (cap_tx[1 + b * CPB + c] !== exp_bit(d, 0, b)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gap0_bits: %0d wrong cycles expected 0", bad);
        end
        checks++;
        if (busy_bad(T0 + 3, T0) != -1) begin
            errors++;
            $display("FAIL gap0_busy: wrong at cycle %0d expected high only for 1..%0d", busy_bad(T0 + 3, T0), T0);
        end
        checks++;
        if (count_done(T0 + 3) != 1 || first_done(T0 + 3) != T0 + 1) begin
            errors++;
            $display("FAIL gap0_done: got %0d pulses first at %0d expected 1 at %0d", count_done(T0 + 3), first_done(T0 + 3), T0 + 1);
        end
    endtask
    task automatic test_rst_mid;
        logic [7:0] e [0:8];
        int late_busy = 0;
        e = '{8'h02, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        data_in = 64'h8877665544332211;
        capture(1'b0, 320, -1, -1, 301);
        checks++;
        if ({cap_busy[300], cap_tx[300]} !== 2'b10) begin
            errors++;
            $display("FAIL rst_pre: got busy/tx %b expected 10", {cap_busy[300], cap_tx[300]});
        end
        checks++;
        if ({cap_tx[301], cap_busy[301], cap_done[301]} !== 3'b100) begin
            errors++;
            $display("FAIL rst_abort: got tx/busy/done %b expected 100", {cap_tx[301], cap_busy[301], cap_done[301]});
        end
        for (int k = 301; k <= 320; k++) if (cap_busy[k] !== 1'b0 || cap_tx[k] !== 1'b1) late_busy++;
        checks++;
        if (late_busy != 0 || count_done(320) != 0) begin
            errors++;
            $display("FAIL rst_after: %0d non-idle cycles, %0d done pulses, expected 0 and 0", late_busy, count_done(320));
        end
        data_in = 64'hDEADBEEFCAFEF00D;
        capture(1'b0, T1 + 3, -1, -1, -1);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (decode(1, i) !== e[i]) begin
                errors++;
                $display("FAIL rst_new_byte_%0d: got %h expected %h", i, decode(1, i), e[i]);
            end
        end
        checks++;
        if (count_done(T1 + 3) != 1 || first_done(T1 + 3) != T1 + 1) begin
            errors++;
            $display("FAIL rst_new_done: got %0d pulses first at %0d expected 1 at %0d", count_done(T1 + 3), first_done(T1 + 3), T1 + 1);
        end
    endtask
    initial begin
        test_reset;
        test_frame;
        test_payload_latch;
        test_back_to_back;
        test_gap0;
        test_rst_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_packet_tx.md
Name: uart_packet_tx

Overview:
- Serial transmitter that is the companion to the team's packet UART receiver.
- Takes a 64-bit payload and sends one 9-byte frame on a single TX line: header byte 0x02, then payload bytes 0..7, least significant byte first.
- Each byte is sent as 8N1 (one start bit, 8 data bits LSB-first, one stop bit).
- Sits between the AES/data path and the RS232 pin; the receiver side feeds tx_start / data_out straight into it for loopback.

Parameters:
- CLKS_PER_BIT, 2474, clk cycles per bit time; matches receiver timing (2 x 1237); legal range 4..65535.
- HEADER, 8'h02, first byte of every frame.
- GAP_BITS, 1, idle-high bit times inserted between bytes (0..15); no gap after the last byte.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  64  payload; sampled only on an accepted tx_start.
- tx_start  in  1  one-cycle request pulse; level-held is treated as repeated pulses.
- tx  out  1  serial line; idle high.
- busy  out  1  high from the cycle after acceptance until frame end.
- done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (synchronous, active-high): tx=1, busy=0, done=0, state=IDLE, all counters 0, shift register 0.
- Baud timing:
  - 16-bit bit-timer counts 0..CLKS_PER_BIT-1.
  - A bit-tick occurs when the count reaches CLKS_PER_BIT-1, then the count wraps to 0.
  - Every bit, including each gap bit, lasts exactly CLKS_PER_BIT cycles.
- Acceptance: tx_start=1 while state=IDLE at edge N.
  - payload <= data_in, byte_idx <= 0, cur_byte <= HEADER.
  - At edge N+1: tx=0 (start bit), busy=1.
  - tx_start while busy is ignored; no queuing, no corruption of the frame in progress.
- tx is registered (no combinational path from inputs to tx).
- States:
  - IDLE: tx=1. On accept -> START.
  - START: tx=0 for 1 bit -> DATA with bit_idx=0.
  - DATA: tx=cur_byte[bit_idx]. On bit-tick: bit_idx+1; after bit 7 -> STOP.
  - STOP: tx=1 for 1 bit. On tick:
    - if byte_idx==8 -> DONE;
    - else load the next byte (cur_byte <= payload[8*byte_idx +: 8], then byte_idx+1), and go to GAP if GAP_BITS>0, otherwise START.
  - GAP: tx=1 for GAP_BITS bit times -> START.
  - DONE: single cycle; done=1, busy=0, tx=1 -> IDLE.
    - A tx_start arriving in DONE is ignored.
    - The earliest new acceptance is the following cycle, in IDLE.
- Byte order on the wire: HEADER, data_in[7:0], [15:8], ..., [63:56].
- Frame length: 90 + 8*GAP_BITS bit times.
  - Start bit of the header at edge N+1.
  - done=1 at edge N+1 + (90+8*GAP_BITS)*CLKS_PER_BIT.
- Payload is latched at acceptance; changes on data_in during the frame have no effect.
- rst mid-frame: next edge gives tx=1, busy=0, done=0, IDLE. The frame is aborted, no done pulse.
- Simultaneous rst and tx_start: rst wins; the request is dropped.

Test Plan:
- Reset, then idle 100 cycles with no tx_start -> tx=1, busy=0, done=0 throughout.
- CLKS_PER_BIT=16, GAP_BITS=1; data_in=64'h8877665544332211, tx_start pulse at edge N.
  - Decoded bytes on tx: 02 11 22 33 44 55 66 77 88.
  - Each start bit 0, each stop bit 1, every bit 16 cycles wide.
  - done pulse at edge N+1+1568; busy high from N+1 to N+1568.
- Same frame with data_in changed to 0 at N+5, and tx_start re-pulsed at N+200 -> wire bytes unchanged; exactly one done pulse.
- GAP_BITS=0, data_in=64'hFF00FF00FF00FF00 -> 90 bit times; stop bit immediately followed by the next start bit; done at N+1+1440.
- rst asserted at N+300 mid-frame -> tx=1, busy=0 at N+301; no done pulse. A new tx_start at N+310 produces a complete, correct frame.
- Loopback: connect tx to the packet receiver (default CLKS_PER_BIT); send 64'h0123456789ABCDEF -> receiver accepts the 0x02 header, pulses its tx_start, and its data_out matches the byte ordering.
